// File: rtl/sync_fifo_stat.sv
// sync_fifo_stat: single-clock FIFO with occupancy count, watermarks and sticky error flags
//
// Ports:
//    clk          rising-edge clock
//    rst          asynchronous active-low reset
//    w_en         write request; accepted when not full
//    data_in      write data
//    r_en         read request (pop/acknowledge in FWFT mode); accepted when not empty
//    clr_err      synchronous clear of overflow/underflow (a new error in the same cycle wins)
//    data_out     read data
//    full/empty   count == DEPTH / count == 0
//    almost_full  count >= AF_LEVEL
//    almost_empty count <= AE_LEVEL
//    count        occupancy 0..DEPTH
//    overflow     sticky: write attempted while full
//    underflow    sticky: read attempted while empty
//
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads; otherwise data_out is registered.
module sync_fifo_stat #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 3,
   parameter int AF_LEVEL   = 6,
   parameter int AE_LEVEL   = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  w_en,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic                  r_en,
   input  logic                  clr_err,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  full,
   output logic                  empty,
   output logic                  almost_full,
   output logic                  almost_empty,
   output logic [ADDR_WIDTH:0]   count,
   output logic                  overflow,
   output logic                  underflow
);
   localparam int              DEPTH = 2 ** ADDR_WIDTH;
   localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH + 1)'(DEPTH);
   localparam logic [ADDR_WIDTH:0] AF_C    = (ADDR_WIDTH + 1)'(AF_LEVEL);
   localparam logic [ADDR_WIDTH:0] AE_C    = (ADDR_WIDTH + 1)'(AE_LEVEL);
   localparam logic [ADDR_WIDTH:0] ONE     = (ADDR_WIDTH + 1)'(1);
   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [ADDR_WIDTH:0]   wptr_q, wptr_d, rptr_q, rptr_d;
   logic                  ovf_q, ovf_d, unf_q, unf_d, wr_acc, rd_acc;
   // pointer difference is modulo 2**(ADDR_WIDTH+1), so the wrap bit disambiguates full from empty
   assign count        = wptr_q - rptr_q;
   assign full         = count == DEPTH_C;
   assign empty        = count == '0;
   assign almost_full  = count >= AF_C;
   assign almost_empty = count <= AE_C;
   assign overflow     = ovf_q;
   assign underflow    = unf_q;
   assign wr_acc       = w_en && !full;
   assign rd_acc       = r_en && !empty;
   always_comb begin
      wptr_d = wr_acc ? wptr_q + ONE : wptr_q;
      rptr_d = rd_acc ? rptr_q + ONE : rptr_q;
      ovf_d  = (w_en && full) || (ovf_q && !clr_err);
      unf_d  = (r_en && empty) || (unf_q && !clr_err);
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wptr_q <= '0;
         rptr_q <= '0;
         ovf_q  <= 1'b0;
         unf_q  <= 1'b0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         ovf_q  <= ovf_d;
         unf_q  <= unf_d;
      end
   end
   always_ff @(posedge clk) begin
      if (wr_acc) mem_q[wptr_q[ADDR_WIDTH-1:0]] <= data_in;
   end
`ifdef SYNC_FIFO_FWFT_EN
   // head word shown whenever non-empty; forced to zero while empty so reset shows zero
   assign data_out = empty ? '0 : mem_q[rptr_q[ADDR_WIDTH-1:0]];
`else
   logic [DATA_WIDTH-1:0] dout_q;
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) dout_q <= '0;
      else if (rd_acc) dout_q <= mem_q[rptr_q[ADDR_WIDTH-1:0]];
   end
   assign data_out = dout_q;
`endif
endmodule

// File: tb/tb_sync_fifo_stat.sv
// tb_sync_fifo_stat: directed plus random checks of sync_fifo_stat against a queue model
module tb_sync_fifo_stat;
   logic       clk = 0, rst = 0, w_en = 0, r_en = 0, clr_err = 0;
   logic [7:0] data_in = 0, data_out;
   logic       full, empty, almost_full, almost_empty, overflow, underflow;
   logic [3:0] count;
   int         total = 0, bad = 0;
   int         q[$];
   bit         m_ovf = 0, m_unf = 0;
   int         m_dout = 0;

   sync_fifo_stat dut (
      .clk(clk), .rst(rst), .w_en(w_en), .data_in(data_in), .r_en(r_en), .clr_err(clr_err),
      .data_out(data_out), .full(full), .empty(empty), .almost_full(almost_full),
      .almost_empty(almost_empty), .count(count), .overflow(overflow), .underflow(underflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      chk("count", 32'(count), q.size());
      chk("empty", 32'(empty), 32'(q.size() == 0));
      chk("full", 32'(full), 32'(q.size() == 8));
      chk("almost_full", 32'(almost_full), 32'(q.size() >= 6));
      chk("almost_empty", 32'(almost_empty), 32'(q.size() <= 2));
      chk("overflow", 32'(overflow), 32'(m_ovf));
      chk("underflow", 32'(underflow), 32'(m_unf));
`ifdef SYNC_FIFO_FWFT_EN
      chk("data_out", 32'(data_out), q.size() != 0 ? q[0] : 0);
`else
      chk("data_out", 32'(data_out), m_dout);
`endif
   endtask

   task automatic cyc(input bit w, input logic [7:0] d, input bit r, input bit c);
      bit f, e;
      int v;
      f = q.size() == 8;
      e = q.size() == 0;
      w_en = w; data_in = d; r_en = r; clr_err = c;
      @(posedge clk);
      m_ovf = (w && f) || (m_ovf && !c);
      m_unf = (r && e) || (m_unf && !c);
      if (r && !e) begin
         v = q.pop_front();
         m_dout = v;
      end
      if (w && !f) q.push_back(int'(d));
      #1 check_all();
   endtask

   task automatic do_reset();
      w_en = 0; r_en = 0; clr_err = 0;
      rst = 0;
      #1;
      q.delete(); m_ovf = 0; m_unf = 0; m_dout = 0;
      check_all();
      @(posedge clk);
      #1 check_all();
      rst = 1;
   endtask

   initial begin
      do_reset();
      for (int i = 1; i <= 8; i++) begin
         cyc(1, 8'(i), 0, 0);
         if (i == 2) chk("ae_at2", 32'(almost_empty), 1);
         if (i == 3) chk("ae_drop3", 32'(almost_empty), 0);
         if (i == 5) chk("af_at5", 32'(almost_full), 0);
         if (i == 6) chk("af_rise6", 32'(almost_full), 1);
      end
      chk("full8", 32'(full), 1);
      cyc(1, 8'hFF, 0, 0);
      chk("ovf9", 32'(overflow), 1);
      chk("cnt9", 32'(count), 8);
      for (int i = 1; i <= 8; i++) begin
         cyc(0, 0, 1, 0);
`ifndef SYNC_FIFO_FWFT_EN
         chk("rd_order", 32'(data_out), i);
`endif
      end
      chk("empty8", 32'(empty), 1);
      cyc(0, 0, 1, 0);
      chk("unf9", 32'(underflow), 1);
`ifndef SYNC_FIFO_FWFT_EN
      chk("hold08", 32'(data_out), 8);
`endif
      cyc(0, 0, 0, 1);
      chk("clr_both", 32'({overflow, underflow}), 0);
      for (int i = 0; i < 4; i++) cyc(1, 8'(8'h20 + i), 0, 0);
      for (int i = 0; i < 20; i++) cyc(1, 8'(8'h40 + i), 1, 0);
      chk("steady4", 32'(count), 4);
      chk("no_err", 32'({overflow, underflow}), 0);
      for (int i = 0; i < 4; i++) cyc(1, 8'(8'h60 + i), 0, 0);
      cyc(1, 8'h77, 1, 0);
      chk("full_rw_cnt", 32'(count), 7);
      chk("full_rw_ovf", 32'(overflow), 1);
      cyc(0, 0, 0, 1);
      for (int i = 0; i < 7; i++) cyc(0, 0, 1, 0);
      cyc(1, 8'h99, 1, 0);
      chk("empty_rw_cnt", 32'(count), 1);
      chk("empty_rw_unf", 32'(underflow), 1);
      cyc(1, 8'h11, 1, 1);
      chk("set_wins", 32'(underflow), 0);
      for (int i = 0; i < 5; i++) cyc(1, 8'(8'h80 + i), 0, 0);
      do_reset();
      chk("rst_cnt", 32'(count), 0);
      cyc(1, 8'h3C, 0, 0);
`ifdef SYNC_FIFO_FWFT_EN
      chk("fwft_3c", 32'(data_out), 32'h3C);
`endif
      cyc(0, 0, 1, 0);
`ifndef SYNC_FIFO_FWFT_EN
      chk("rd_3c", 32'(data_out), 32'h3C);
`else
      cyc(1, 8'hA5, 0, 0);
      chk("fwft_a5", 32'(data_out), 32'hA5);
      cyc(1, 8'h5A, 0, 0);
      cyc(0, 0, 1, 0);
      chk("fwft_5a", 32'(data_out), 32'h5A);
`endif
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 99) == 0) do_reset();
         else cyc(1'($urandom_range(0, 99) < (i % 200 < 100 ? 70 : 30)), 8'($urandom),
                  1'($urandom_range(0, 99) < (i % 200 < 100 ? 30 : 70)), 1'($urandom_range(0, 9) == 0));
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
